load_store_unit: RTL and testbench

Sequencer between instruction decode and the 8-bit data memory.
- Accepts one decoded memory instruction at a time over a valid/ready handshake and computes the effective address.
- Drives the memory's opcode, address and store-data inputs for exactly one cycle.
- Returns load results to the register file as a one-cycle writeback pulse.
- Guarantees the memory never sees a held or repeated load/store opcode.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/load_store_unit.sv | 93 +++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared opcode constants and state encoding for the load/store unit and the
// data memory it drives.
package lsu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd13;
  localparam logic [3:0] OP_STORE = 4'd14;
  localparam logic [3:0] OP_LADDR = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } lsu_state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_LADDR);
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Sequences one decoded memory instruction at a time into the 8-bit data
// memory and returns load results as a single-cycle writeback pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [7:0]            in_base,
  input  logic [7:0]            in_offset,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [7:0]            in_store_data,
  output logic [3:0]            mem_op,
  output logic [7:0]            mem_addr,
  output logic [7:0]            mem_ra,
  input  logic [7:0]            mem_read_data,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [7:0]            wb_data,
  output logic                  illegal_op,
  output logic [1:0]            dbg_state
);

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on state, never on in_valid.

  lsu_state_t            state, state_next;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [7:0]            eff_addr;
  logic                  accept;

  assign eff_addr = in_base + in_offset;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem_op(in_op)) state_next = ACCESS;
      // mem_op still holds the issued opcode throughout ACCESS.
      ACCESS:  state_next = (mem_op == OP_STORE) ? IDLE : CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    dbg_state = state;
  end

  // mem_op defaults to NOP every edge so the memory never sees a held opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_op     <= OP_NOP;
      mem_addr   <= 8'd0;
      mem_ra     <= 8'd0;
      rd_q       <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= 8'd0;
      illegal_op <= 1'b0;
    end else begin
      mem_op     <= OP_NOP;
      wb_valid   <= 1'b0;
      illegal_op <= 1'b0;
      if (state == IDLE && accept) begin
        if (is_mem_op(in_op)) begin
          mem_op   <= in_op;
          mem_addr <= eff_addr;
          mem_ra   <= in_store_data;
          rd_q     <= in_rd;
        end else begin
          illegal_op <= 1'b1;
        end
      end
      if (state == CAPTURE) begin
        wb_data  <= mem_read_data;
        wb_rd    <= rd_q;
        wb_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Pairs the load/store unit with a small data memory whose cells start at
// their own address, and checks directed instruction vectors cycle by cycle.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [7:0]    in_base;
  logic [7:0]    in_offset;
  logic [RW-1:0] in_rd;
  logic [7:0]    in_store_data;
  logic [3:0]    mem_op;
  logic [7:0]    mem_addr;
  logic [7:0]    mem_ra;
  logic [7:0]    mem_read_data;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [7:0]    wb_data;
  logic          illegal_op;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  int wb_cnt = 0;
  int op_cnt = 0;

  load_store_unit #(.REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_base(in_base), .in_offset(in_offset), .in_rd(in_rd),
    .in_store_data(in_store_data),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_ra(mem_ra),
    .mem_read_data(mem_read_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // data memory: registered read, load-address echoes the address
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = i[7:0];
  always @(posedge clk) begin
    case (mem_op)
      OP_LOAD:  mem_read_data <= mem[mem_addr];
      OP_LADDR: mem_read_data <= mem_addr;
      OP_STORE: mem[mem_addr] <= mem_ra;
      default:  ;
    endcase
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (wb_valid)        wb_cnt <= wb_cnt + 1;
      if (mem_op != OP_NOP) op_cnt <= op_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [7:0]    base;
    logic [7:0]    offset;
    logic [RW-1:0] rd;
    logic [7:0]    sdata;
    logic [7:0]    exp_addr;
    logic [7:0]    exp_wb_data;
  } vec_t;

  // drive at a negedge where in_ready is expected high; returns one cycle
  // after the last observable effect of the instruction
  task automatic run_vec(input vec_t v);
    logic legal;
    int   wb0;
    legal = is_mem_op(v.op);
    chk("ready_before", in_ready, 1);
    in_valid = 1'b1; in_op = v.op; in_base = v.base; in_offset = v.offset;
    in_rd = v.rd; in_store_data = v.sdata;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wb0 = wb_cnt;
    if (!legal) begin
      chk("illegal_pulse", illegal_op, 1);
      chk("illegal_mem_op", mem_op, OP_NOP);
      chk("illegal_ready", in_ready, 1);
      @(negedge clk);
      chk("illegal_pulse_end", illegal_op, 0);
      chk("illegal_no_op", mem_op, OP_NOP);
      return;
    end
    chk("mem_op", mem_op, v.op);
    chk("mem_addr", mem_addr, v.exp_addr);
    if (v.op == OP_STORE) chk("mem_ra", mem_ra, v.sdata);
    chk("busy_ready", in_ready, 0);
    @(negedge clk);
    chk("mem_op_one_cycle", mem_op, OP_NOP);
    chk("no_early_wb", wb_valid, 0);
    if (v.op == OP_STORE) begin
      chk("store_ready", in_ready, 1);
      @(negedge clk);
      chk("store_no_wb", wb_cnt - wb0, 0);
      return;
    end
    chk("capture_ready", in_ready, 0);
    @(negedge clk);
    chk("wb_valid", wb_valid, 1);
    chk("wb_rd", wb_rd, v.rd);
    chk("wb_data", wb_data, v.exp_wb_data);
    chk("wb_ready", in_ready, 1);
    @(negedge clk);
    chk("wb_pulse_end", wb_valid, 0);
  endtask

  vec_t vecs [10];

  initial begin
    int ops0, wbs0;
    vecs[0] = '{OP_LOAD,  8'h10, 8'h05, 2'd2, 8'h00, 8'h15, 8'h15};
    vecs[1] = '{OP_STORE, 8'hF0, 8'h20, 2'd0, 8'hAB, 8'h10, 8'h00};
    vecs[2] = '{OP_LOAD,  8'h08, 8'h08, 2'd3, 8'h00, 8'h10, 8'hAB};
    vecs[3] = '{OP_LADDR, 8'h7F, 8'h00, 2'd1, 8'h00, 8'h7F, 8'h7F};
    vecs[4] = '{4'd3,     8'h11, 8'h22, 2'd1, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{OP_LOAD,  8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{OP_LOAD,  8'hFF, 8'h00, 2'd3, 8'h00, 8'hFF, 8'hFF};
    vecs[7] = '{OP_STORE, 8'h80, 8'h7F, 2'd0, 8'h5A, 8'hFF, 8'h00};
    vecs[8] = '{OP_LOAD,  8'hFE, 8'h01, 2'd2, 8'h00, 8'hFF, 8'h5A};
    vecs[9] = '{OP_NOP,   8'h01, 8'h01, 2'd2, 8'h00, 8'h00, 8'h00};

    rst = 1'b0; in_valid = 1'b0; in_op = '0; in_base = '0; in_offset = '0;
    in_rd = '0; in_store_data = '0;
    #3 rst = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_mem_op", mem_op, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_ra", mem_ra, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // load with in_valid held high through its busy cycles
    ops0 = op_cnt; wbs0 = wb_cnt;
    in_valid = 1'b1; in_op = OP_LOAD; in_base = 8'h20; in_offset = 8'h03; in_rd = 2'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_wb_valid", wb_valid, 1);
    chk("stall_wb_data", wb_data, 8'h23);
    repeat (3) @(negedge clk);
    chk("stall_one_op", op_cnt - ops0, 1);
    chk("stall_one_wb", wb_cnt - wbs0, 1);

    // reset during ACCESS of a load
    wbs0 = wb_cnt;
    in_valid = 1'b1; in_op = OP_LOAD; in_base = 8'h40; in_offset = 8'h02; in_rd = 2'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid_issued", mem_op, OP_LOAD);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_op", mem_op, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_wb", wb_cnt - wbs0, 0);
    chk("rst_mid_ready_after", in_ready, 1);
    chk("rst_mid_state", dbg_state, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
